// File: rtl/alu_operand_sampler_if.sv
// alu_operand_sampler_if: operation bundle handshake between the operand sampler and the ALU
//   op_valid       sampler -> ALU  bundle valid
//   op_ready       ALU -> sampler  ALU accepts the current bundle
//   a0, b0, a1, b1 sampler -> ALU  4-bit operands
//   sel1, sel2     sampler -> ALU  2-bit ALU selects
interface alu_operand_sampler_if;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] sel1, sel2;
    modport master(output op_valid, a0, b0, a1, b1, sel1, sel2, input op_ready);
    modport slave(input op_valid, a0, b0, a1, b1, sel1, sel2, output op_ready);
endinterface

// File: rtl/alu_operand_sampler.sv
// alu_operand_sampler: synchronizes and debounces the 20 raw pad bits, then issues each new stable word as one valid/ready operation
//   wb_clk_i, wb_rst_i  clock, synchronous active-high reset
//   io_in[19:0]         asynchronous pad bits {sel2, sel1, b1, a1, b0, a0}
//   en                  issue enable
//   bus                 master side of the operation bundle (op_valid/op_ready, operands, selects)
//   drop_flag           sticky: a qualified word was overwritten in the pending slot
//   clear_drop          clears drop_flag (a same-cycle drop wins)
//   issue_cnt           completed handshakes, wraps
//   ALU_SAMPLER_DBG_EN  when defined, adds registered debug copies dbg_cand, dbg_pend_v, dbg_stab
module alu_operand_sampler #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [19:0]           io_in,
    input  logic                  en,
    input  logic                  clear_drop,
    alu_operand_sampler_if.master bus,
    output logic                  drop_flag,
    output logic [CNT_W-1:0]      issue_cnt
`ifdef ALU_SAMPLER_DBG_EN
    ,
    output logic [19:0]           dbg_cand,
    output logic [0:0]            dbg_pend_v,
    output logic [7:0]            dbg_stab
`endif
);
    localparam logic [0:0] EMPTY = 1'b0, VALID = 1'b1;
    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);
    logic [19:0] s1, s2, cand, last, pend, word;
    logic [7:0]  stab;
    logic [0:0]  state;
    logic        done, first, pend_v, qual, req, drop_set;
    // done makes each candidate load qualify only once
    assign qual     = (s2 == cand) && (stab == STAB_MAX) && !done;
    assign req      = qual && en && ((cand != last) || first);
    assign drop_set = req && (state == VALID) && !bus.op_ready && pend_v;
    assign bus.op_valid = state == VALID;
    assign {bus.sel2, bus.sel1, bus.b1, bus.a1, bus.b0, bus.a0} = word;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1        <= '0;
            s2        <= '0;
            cand      <= '0;
            stab      <= '0;
            done      <= 1'b0;
            last      <= '0;
            first     <= 1'b1;
            pend      <= '0;
            pend_v    <= 1'b0;
            word      <= '0;
            state     <= EMPTY;
            drop_flag <= 1'b0;
            issue_cnt <= '0;
        end else begin
            s1 <= io_in;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                stab <= '0;
                done <= 1'b0;
            end else begin
                if (stab < STAB_MAX) stab <= stab + 8'd1;
                if (qual) done <= 1'b1;
            end
            // every request is accepted somewhere (output or pending)
            if (req) begin
                last  <= cand;
                first <= 1'b0;
            end
            if (bus.op_valid && bus.op_ready) issue_cnt <= issue_cnt + CNT_W'(1);
            if (state == EMPTY) begin
                if (req) begin
                    word  <= cand;
                    state <= VALID;
                end
            end else if (bus.op_ready) begin
                if (pend_v) begin
                    word   <= pend;
                    pend_v <= req;
                    if (req) pend <= cand;
                end else if (req) word <= cand;
                else state <= EMPTY;
            end else if (req) begin
                pend   <= cand;
                pend_v <= 1'b1;
            end
            if (drop_set) drop_flag <= 1'b1;
            else if (clear_drop) drop_flag <= 1'b0;
        end
    end
`ifdef ALU_SAMPLER_DBG_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            dbg_cand   <= '0;
            dbg_pend_v <= '0;
            dbg_stab   <= '0;
        end else begin
            dbg_cand   <= cand;
            dbg_pend_v <= pend_v;
            dbg_stab   <= stab;
        end
    end
`endif
endmodule

// File: doc/alu_operand_sampler.md
Name: alu_operand_sampler

Overview:
- Upstream stage of the dual 4-bit ALU user macro.
- Takes the 20 raw pad-input bits that carry {ALU_Sel2, ALU_Sel1, B1, A1, B0, A0} from mprj_io[37:18] and synchronizes them.
- Accepts a word only after it has been stable for a set number of cycles, then issues it to the ALU as one valid/ready operation.
- A one-entry pending slot absorbs backpressure. A sticky flag reports any word that had to be dropped.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles a synchronized word must hold before it qualifies; legal range 1..255.
- CNT_W, 16: width of the issue counter.

Ports:
- wb_clk_i  input  1  single clock.
- wb_rst_i  input  1  reset; synchronous, active-high.
- io_in  input  20  asynchronous pad bits. [3:0]=A0, [7:4]=B0, [11:8]=A1, [15:12]=B1, [17:16]=ALU_Sel1, [19:18]=ALU_Sel2.
- en  input  1  issue enable.
- op_ready  input  1  ALU accepts the current operation.
- op_valid  output  1  operation bundle valid.
- a0, b0, a1, b1  output  4 each  operands.
- sel1, sel2  output  2 each  ALU selects.
- drop_flag  output  1  sticky: a qualified word was lost.
- clear_drop  input  1  clears drop_flag.
- issue_cnt  output  CNT_W  completed handshakes.

Behaviour:
- Reset (wb_rst_i high at a clock edge): all registers clear.
  - Outputs: op_valid=0, operands/selects=0, drop_flag=0, issue_cnt=0.
  - Internal: sync flops=0, candidate=0, stability count=0, pending empty, last_issued=0, first_flag=1.
- Reset mid-operation discards the output word and the pending word; issue_cnt is not incremented.
- Synchronizer: two flops, s1 <= io_in, s2 <= s1.
- Stability filter:
  - If s2 != cand: cand <= s2 and cnt <= 0.
  - Else if cnt < STABLE_CYCLES-1: cnt increments.
  - At the edge where s2 == cand and cnt == STABLE_CYCLES-1, cand qualifies. It qualifies exactly once per candidate load; a done bit is set and cleared when cand reloads.
- Issue filter: a qualified word is an issue request only if en=1 AND (cand != last_issued OR first_flag=1).
  - Qualifications while en=0 are discarded silently; no drop is flagged.
  - last_issued <= cand and first_flag <= 0 whenever a request is accepted into the output register or the pending slot.
- Latency: for a clean io_in change at edge 0 with an EMPTY output, op_valid is high after edge 3+STABLE_CYCLES (edge 7 at default).
- Output FSM, states EMPTY and VALID; op_valid = (state==VALID).
  - EMPTY, request: load outputs, go to VALID.
  - VALID, op_ready=1, pending full: load outputs from pending, clear pending, stay VALID. A same-cycle request goes into pending.
  - VALID, op_ready=1, pending empty, request: load outputs from the request, stay VALID.
  - VALID, op_ready=1, pending empty, no request: go to EMPTY; outputs hold their last value.
  - VALID, op_ready=0, request: write into pending. If pending is already full, overwrite it and set drop_flag.
- While VALID and op_ready=0, outputs must not change.
- issue_cnt increments on every edge with op_valid & op_ready and wraps modulo 2^CNT_W.
- drop_flag: a set event in the same cycle as clear_drop wins (flag stays 1). Otherwise clear_drop clears it.
- Fields are mapped straight from io_in bits; there is no arithmetic on operands.

Optional Feature:
- Macro: ALU_SAMPLER_DBG_EN.
- Defined: adds outputs dbg_cand [19:0] (candidate register), dbg_pend_v [0:0] (pending occupied) and dbg_stab [7:0] (stability count). These outputs are registered copies and have no effect on function.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic issue: release reset, op_ready=1, en=1, drive io_in=20'h00099 and hold. Required: op_valid high after edge 7 with a0=9, b0=9, a1=0, b1=0, sel1=0, sel2=0; one-cycle handshake; issue_cnt=1; op_valid then drops.
- Glitch reject: from a stable 20'h00099, pulse io_in=20'h000FF for 2 cycles, then return. Required: no new op_valid, issue_cnt unchanged.
- Backpressure/drop: op_ready=0, then qualify 20'h00011, 20'h00022 and 20'h00033 in turn. Required: outputs hold 0x11, pending holds 0x33, drop_flag=1. With op_ready=1, 0x11 is accepted, then 0x33; issue_cnt += 2.
- Enable gating: en=0 and qualify 20'hA5A5A. Required: no issue, drop_flag=0. Then en=1 with the word unchanged: still no issue, because it never re-qualifies. A change to 20'hA5A5B then issues.
- Reset mid-operation: op_valid=1, pending full, assert wb_rst_i for one edge. Required: op_valid=0, issue_cnt=0, pending empty. The next stable word issues even if it equals 0.
- Counter wrap: with CNT_W=4, complete 17 handshakes. Required: issue_cnt=1.
